// File: rtl/tx_fsm.sv
`default_nettype none
// ============================================================================
// Module  : tx_fsm
// Purpose : Byte-wide transmit framer: SFD, TYPE, SIZE, PAYLOAD, FCS, then IFG.
// Rev     : 1.0  initial release
// ============================================================================
module tx_fsm #(
  parameter logic [31:0] C_SFD              = 32'h5555557F,
  parameter logic [15:0] C_PACKET_TYPE      = 16'h1234,
  parameter logic [7:0]  C_SIZE_MIN         = 8'h08,
  parameter int          MAX_PACKET_CNT_VAL = 20,
  parameter int          IFG_CYCLES         = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  input  logic [7:0]  size_in,
  input  logic        fcs_corrupt_in,
  input  logic [7:0]  s_data_in,
  input  logic        s_valid_in,
  output logic        s_ready_out,
  output logic [7:0]  txd_out,
  output logic        txdv_out,
  output logic        txer_out,
  output logic        busy_out,
  output logic        start_err_out,
  output logic        abort_out,
  output logic [15:0] stat_packet_sent_cnt,
  output logic [15:0] stat_packet_abort_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SFD     = 3'd1,
    S_TYPE    = 3'd2,
    S_SIZE    = 3'd3,
    S_PAYLOAD = 3'd4,
    S_FCS     = 3'd5,
    S_GAP     = 3'd6
  } state_t;

  localparam logic [15:0] C_CNT_MAX  = 16'(MAX_PACKET_CNT_VAL);
  localparam logic [7:0]  C_GAP_LAST = 8'(IFG_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [7:0]  r_size;
  logic        r_corrupt;
  logic        r_aborted;
  logic [9:0]  r_sum;
  logic [7:0]  r_txd;
  logic        r_txdv;
  logic        r_txer;
  logic        r_start_err;
  logic        r_abort;
  logic [15:0] r_sent_cnt;
  logic [15:0] r_abort_cnt;

  logic        w_ready;
  logic        w_take;
  logic        w_sum_en;
  logic [7:0]  w_fcs;

  // r_state names the field currently on txd_out; a byte accepted now is shown next cycle.
  assign w_ready  = !r_aborted &&
                    ((r_state == S_SIZE) ||
                     ((r_state == S_PAYLOAD) && (r_cnt < (r_size - 8'd1))));
  assign w_take   = w_ready && s_valid_in;
  assign w_sum_en = w_take && ((r_state == S_SIZE) || (r_cnt < 8'd3));
  assign w_fcs    = r_sum[7:0] ^ {7'b0, r_corrupt};

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_size      <= 8'd0;
      r_corrupt   <= 1'b0;
      r_aborted   <= 1'b0;
      r_sum       <= 10'd0;
      r_txd       <= 8'd0;
      r_txdv      <= 1'b0;
      r_txer      <= 1'b0;
      r_start_err <= 1'b0;
      r_abort     <= 1'b0;
      r_sent_cnt  <= 16'd0;
      r_abort_cnt <= 16'd0;
    end else begin
      r_start_err <= 1'b0;
      r_abort     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_in) begin
            if (size_in >= C_SIZE_MIN) begin
              r_state   <= S_SFD;
              r_cnt     <= 8'd0;
              r_size    <= size_in;
              r_corrupt <= fcs_corrupt_in;
              r_aborted <= 1'b0;
              r_sum     <= 10'(C_PACKET_TYPE[15:8]) + 10'(C_PACKET_TYPE[7:0]) + 10'(size_in);
              r_txdv    <= 1'b1;
              r_txd     <= C_SFD[31:24];
            end else begin
              r_start_err <= 1'b1;
            end
          end
        end
        S_SFD: begin
          if (r_cnt == 8'd3) begin
            r_state <= S_TYPE;
            r_cnt   <= 8'd0;
            r_txd   <= C_PACKET_TYPE[15:8];
          end else begin
            r_cnt <= r_cnt + 8'd1;
            case (r_cnt[1:0])
              2'd0:    r_txd <= C_SFD[23:16];
              2'd1:    r_txd <= C_SFD[15:8];
              default: r_txd <= C_SFD[7:0];
            endcase
          end
        end
        S_TYPE: begin
          if (r_cnt == 8'd0) begin
            r_cnt <= 8'd1;
            r_txd <= C_PACKET_TYPE[7:0];
          end else begin
            r_state <= S_SIZE;
            r_cnt   <= 8'd0;
            r_txd   <= r_size;
          end
        end
        S_SIZE: begin
          r_state <= S_PAYLOAD;
          r_cnt   <= 8'd0;
          if (w_take) begin
            r_txd <= s_data_in;
          end else begin
            r_txd     <= 8'd0;
            r_txer    <= 1'b1;
            r_aborted <= 1'b1;
            r_abort   <= 1'b1;
          end
        end
        S_PAYLOAD: begin
          if (r_cnt == (r_size - 8'd1)) begin
            r_state <= S_FCS;
            r_txd   <= r_aborted ? 8'd0 : w_fcs;
            r_txer  <= r_aborted;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (w_take) begin
              r_txd <= s_data_in;
            end else begin
              // Once aborted every remaining slot is a zero byte flagged as error.
              r_txd  <= 8'd0;
              r_txer <= 1'b1;
              if (!r_aborted) begin
                r_aborted <= 1'b1;
                r_abort   <= 1'b1;
              end
            end
          end
        end
        S_FCS: begin
          r_state <= S_GAP;
          r_cnt   <= 8'd0;
          r_txd   <= 8'd0;
          r_txdv  <= 1'b0;
          r_txer  <= 1'b0;
          if (r_aborted) begin
            if (r_abort_cnt < C_CNT_MAX) r_abort_cnt <= r_abort_cnt + 16'd1;
          end else begin
            if (r_sent_cnt < C_CNT_MAX) r_sent_cnt <= r_sent_cnt + 16'd1;
          end
        end
        S_GAP: begin
          if (r_cnt == C_GAP_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
      if (w_sum_en) r_sum <= r_sum + {2'b00, s_data_in};
    end
  end

  assign s_ready_out           = w_ready;
  assign txd_out               = r_txd;
  assign txdv_out              = r_txdv;
  assign txer_out              = r_txer;
  assign busy_out              = (r_state != S_IDLE);
  assign start_err_out         = r_start_err;
  assign abort_out             = r_abort;
  assign stat_packet_sent_cnt  = r_sent_cnt;
  assign stat_packet_abort_cnt = r_abort_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tx_fsm.sv
`default_nettype none
// ============================================================================
// Module  : tb_tx_fsm
// Purpose : Self-checking bench for tx_fsm (vector table, random frames, corners).
// Rev     : 1.0  initial release
// ============================================================================
module tb_tx_fsm;

  localparam int IFG  = 2;
  localparam int SATV = 20;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        start_in;
  logic [7:0]  size_in;
  logic        fcs_corrupt_in;
  logic [7:0]  s_data_in;
  logic        s_valid_in;
  logic        s_ready_out;
  logic [7:0]  txd_out;
  logic        txdv_out;
  logic        txer_out;
  logic        busy_out;
  logic        start_err_out;
  logic        abort_out;
  logic [15:0] stat_packet_sent_cnt;
  logic [15:0] stat_packet_abort_cnt;

  always #5 clk_in = ~clk_in;

  tx_fsm #(
    .C_SFD(32'h5555557F), .C_PACKET_TYPE(16'h1234), .C_SIZE_MIN(8'h08),
    .MAX_PACKET_CNT_VAL(SATV), .IFG_CYCLES(IFG)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in), .size_in(size_in),
    .fcs_corrupt_in(fcs_corrupt_in), .s_data_in(s_data_in), .s_valid_in(s_valid_in),
    .s_ready_out(s_ready_out), .txd_out(txd_out), .txdv_out(txdv_out), .txer_out(txer_out),
    .busy_out(busy_out), .start_err_out(start_err_out), .abort_out(abort_out),
    .stat_packet_sent_cnt(stat_packet_sent_cnt), .stat_packet_abort_cnt(stat_packet_abort_cnt)
  );

  typedef struct {
    int         n;
    bit         corrupt;
    int         drop;
    int         pat;
    logic [7:0] fcs;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] pay [0:255];
  int         m_sent = 0;
  int         m_abort = 0;
  vec_t       tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_fcs(input int n, input bit corrupt);
    int s;
    s = 18 + 52 + n + pay[0] + pay[1] + pay[2] + pay[3];
    return 8'(s % 256) ^ {7'b0, corrupt};
  endfunction

  // Expected link byte at frame slot p: 55 55 55 7F 12 34 N P0..P(N-1) FCS.
  function automatic logic [7:0] exp_byte(input int p, input int n, input int drop,
                                          input logic [7:0] fcs);
    if (p < 3) return 8'h55;
    if (p == 3) return 8'h7F;
    if (p == 4) return 8'h12;
    if (p == 5) return 8'h34;
    if (p == 6) return 8'(n);
    if (p < 7 + n) return (drop >= 0 && (p - 7) >= drop) ? 8'h00 : pay[p - 7];
    return (drop >= 0) ? 8'h00 : fcs;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge where it is idle again.
  task automatic run_frame(input int n, input bit corrupt, input int drop,
                           input logic [7:0] fcs, input bit rnd_start);
    int idx = 0, len = 0, gaplen = 0, bad_byte = 0, bad_er = 0;
    int aborts = 0, serrs = 0, cyc = 0;
    bit done = 0;
    start_in = 1'b1; size_in = 8'(n); fcs_corrupt_in = corrupt; s_valid_in = 1'b0;
    @(negedge clk_in);
    start_in = 1'b0;
    while (cyc < 1000) begin
      if (cyc > 0 && !busy_out) begin
        done = 1;
        break;
      end
      if (txdv_out) begin
        if (gaplen > 0) bad_byte++;
        if (txd_out !== exp_byte(len, n, drop, fcs)) bad_byte++;
        if (txer_out !== (drop >= 0 && len >= 7 + drop)) bad_er++;
        len++;
      end else begin
        gaplen++;
        if (txd_out !== 8'h00 || txer_out !== 1'b0) bad_byte++;
      end
      aborts += int'(abort_out);
      serrs  += int'(start_err_out);
      if (s_ready_out) begin
        if (idx == drop) s_valid_in = 1'b0;
        else begin
          s_valid_in = 1'b1;
          s_data_in  = pay[idx];
          idx++;
        end
      end else begin
        s_valid_in = 1'($urandom % 2);
        s_data_in  = 8'($urandom);
      end
      if (rnd_start) begin
        start_in = 1'($urandom % 2);
        size_in  = 8'($urandom);
      end
      @(negedge clk_in);
      cyc++;
    end
    start_in = 1'b0;
    s_valid_in = 1'b0;
    if (drop >= 0) m_abort = (m_abort < SATV) ? m_abort + 1 : m_abort;
    else           m_sent  = (m_sent  < SATV) ? m_sent  + 1 : m_sent;
    chk("frame_done", 32'(done), 32'd1);
    chk("frame_len", len, 8 + n);
    chk("frame_bytes_bad", bad_byte, 0);
    chk("frame_txer_bad", bad_er, 0);
    chk("gap_len", gaplen, IFG);
    chk("accepted", idx, (drop < 0) ? n : drop);
    chk("abort_pulses", aborts, (drop >= 0) ? 1 : 0);
    chk("start_err_busy", serrs, 0);
    chk("sent_cnt", 32'(stat_packet_sent_cnt), m_sent);
    chk("abort_cnt", 32'(stat_packet_abort_cnt), m_abort);
  endtask

  task automatic reject(input int n);
    start_in = 1'b1; size_in = 8'(n); fcs_corrupt_in = 1'b0;
    @(negedge clk_in);
    start_in = 1'b0;
    chk("rej_start_err", 32'(start_err_out), 32'd1);
    chk("rej_busy", 32'(busy_out), 32'd0);
    chk("rej_txdv", 32'(txdv_out), 32'd0);
    @(negedge clk_in);
    chk("rej_pulse_end", 32'(start_err_out), 32'd0);
    chk("rej_txdv2", 32'(txdv_out), 32'd0);
    chk("rej_sent", 32'(stat_packet_sent_cnt), m_sent);
    chk("rej_abort", 32'(stat_packet_abort_cnt), m_abort);
  endtask

  task automatic fill(input int pat);
    for (int k = 0; k < 256; k++) begin
      case (pat)
        0:       pay[k] = 8'(k + 1);
        1:       pay[k] = 8'hFF;
        2:       pay[k] = 8'h00;
        default: pay[k] = 8'($urandom);
      endcase
    end
  endtask

  initial begin
    tbl[0] = '{n: 8,   corrupt: 0, drop: -1, pat: 0, fcs: 8'h58};
    tbl[1] = '{n: 8,   corrupt: 1, drop: -1, pat: 1, fcs: 8'h4B};
    tbl[2] = '{n: 10,  corrupt: 0, drop: 5,  pat: 0, fcs: 8'h00};
    tbl[3] = '{n: 255, corrupt: 0, drop: -1, pat: 2, fcs: 8'h45};
    tbl[4] = '{n: 8,   corrupt: 0, drop: 0,  pat: 0, fcs: 8'h00};
    tbl[5] = '{n: 9,   corrupt: 0, drop: 8,  pat: 0, fcs: 8'h00};
    tbl[6] = '{n: 9,   corrupt: 1, drop: -1, pat: 0, fcs: 8'h58};

    rst_n_in = 1'b0; start_in = 1'b0; size_in = 8'd0; fcs_corrupt_in = 1'b0;
    s_data_in = 8'd0; s_valid_in = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_txdv", 32'(txdv_out), 32'd0);
    chk("rst_txd", 32'(txd_out), 32'd0);
    chk("rst_txer", 32'(txer_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_ready", 32'(s_ready_out), 32'd0);
    chk("rst_cnts", {stat_packet_sent_cnt, stat_packet_abort_cnt}, 32'd0);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    for (int i = 0; i < 7; i++) begin
      fill(tbl[i].pat);
      run_frame(tbl[i].n, tbl[i].corrupt, tbl[i].drop, tbl[i].fcs, bit'(i % 2));
    end

    reject(7);
    reject(0);

    // Reset in the middle of a payload.
    fill(3);
    start_in = 1'b1; size_in = 8'd12; fcs_corrupt_in = 1'b0;
    @(negedge clk_in);
    start_in = 1'b0;
    s_valid_in = 1'b1;
    repeat (9) begin
      s_data_in = 8'($urandom);
      @(negedge clk_in);
    end
    rst_n_in = 1'b0;
    @(negedge clk_in);
    m_sent = 0; m_abort = 0;
    chk("midrst_txdv", 32'(txdv_out), 32'd0);
    chk("midrst_busy", 32'(busy_out), 32'd0);
    chk("midrst_cnts", {stat_packet_sent_cnt, stat_packet_abort_cnt}, 32'd0);
    rst_n_in = 1'b1; s_valid_in = 1'b0;
    fill(0);
    run_frame(8, 1'b0, -1, 8'h58, 1'b0);

    for (int i = 0; i < 20; i++) begin
      int n, drop;
      bit c;
      fill(3);
      n = 8 + int'($urandom % 33);
      c = 1'($urandom % 2);
      drop = ($urandom % 4 == 0) ? int'($urandom % n) : -1;
      run_frame(n, c, drop, model_fcs(n, c), 1'b1);
    end

    // Back-to-back good frames run the sent counter into saturation.
    rst_n_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    m_sent = 0; m_abort = 0;
    fill(0);
    for (int i = 0; i < 25; i++) run_frame(8, 1'b0, -1, 8'h58, 1'b0);
    chk("sat_sent_final", 32'(stat_packet_sent_cnt), SATV);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
